systolic_drain: RTL and testbench

Output-side collector for the weight-stationary systolic array. The array emits per-column partial sums on `of_data` with a one-cycle-per-column skew and no valid or backpressure of its own. `systolic_drain` de-skews each result row, tags it, and buffers it in a first-word-fall-through FIFO. It presents complete rows to the output buffer writer over a valid/ready handshake.

---
 rtl/systolic_drain_pkg.sv | 12 +
 rtl/systolic_drain_sync_fifo.sv | 60 ++++++
 rtl/systolic_drain.sv | 105 ++++++++++
 tb/tb_systolic_drain.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/systolic_drain_pkg.sv
// Shared configuration for the systolic array output path.
// Provides the array geometry (sys_cols, P_BITWIDTH), the de-skewed row type
// and the default depth of the drain FIFO.
package systolic_drain_pkg;

  localparam int sys_cols      = 4;
  localparam int P_BITWIDTH    = 32;
  localparam int OUT_DEPTH_DEF = 8;

  typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] psum_row_t;

endpackage

// File: rtl/systolic_drain_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, push_data   - write request and word
//   pop               - read request; advances the head (ignored when empty)
//   head              - current head word, combinational from the read pointer
//   full, empty       - occupancy flags
//   count             - occupancy, 0..DEPTH
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is not reset; only pointers and occupancy carry state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// Output-side collector for the weight-stationary systolic array.
// De-skews each result row, tags it with its last-of-tile flag and buffers it
// in a FWFT FIFO presented over valid/ready.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid, in_last     - row start (column 0 valid) and its last-of-tile tag
//   of_data               - skewed array outputs, column j lags by j cycles
//   out_valid, out_ready  - head-row handshake
//   out_data, out_last    - de-skewed head row and its tag
//   count                 - FIFO occupancy
//   overflow              - sticky, a row was dropped on a full FIFO
module systolic_drain
  import systolic_drain_pkg::*;
#(
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  psum_row_t                      of_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output psum_row_t                      out_data,
  output logic                           out_last,
  output logic [$clog2(OUT_DEPTH+1)-1:0] count,
  output logic                           overflow
);

  localparam int FW = P_BITWIDTH * sys_cols + 1;

  wire psum_row_t       aligned;
  logic [sys_cols-2:0]  v_sr;
  logic [sys_cols-2:0]  l_sr;
  logic                 wr_en;
  logic                 wr_last;
  logic                 pop;
  logic                 push;
  logic                 full;
  logic                 empty;
  logic [FW-1:0]        head;

  // Column j arrives j cycles after column 0; delaying it by sys_cols-1-j
  // lines every column up with the last one, which is used as-is.
  for (genvar j = 0; j < sys_cols; j++) begin : g_col
    if (j == sys_cols - 1) begin : g_direct
      assign aligned[j] = of_data[j];
    end else begin : g_dly
      localparam int D = sys_cols - 1 - j;
      logic [P_BITWIDTH-1:0] dl [D];
      always_ff @(posedge clk) begin
        dl[0] <= of_data[j];
        for (int k = 1; k < D; k++) dl[k] <= dl[k-1];
      end
      assign aligned[j] = dl[D-1];
    end
  end

  // Row-start tag follows the same skew so its tail coincides with alignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_sr <= '0;
      l_sr <= '0;
    end else begin
      v_sr[0] <= in_valid;
      l_sr[0] <= in_valid && in_last;
      for (int k = 1; k < sys_cols - 1; k++) begin
        v_sr[k] <= v_sr[k-1];
        l_sr[k] <= l_sr[k-1];
      end
    end
  end

  assign wr_en   = v_sr[sys_cols-2];
  assign wr_last = l_sr[sys_cols-2];

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the row when the head leaves in the same cycle.
  assign push      = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst)                          overflow <= 1'b0;
    else if (wr_en && full && !pop)   overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({wr_last, aligned}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign out_last = head[FW-1];
  assign out_data = head[FW-2:0];

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;
  import systolic_drain_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  psum_row_t   of_data;
  logic        out_valid;
  logic        out_ready;
  psum_row_t   out_data;
  logic        out_last;
  logic [3:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [128:0]  sb [$];
  logic [31:0]   lane_d [4][64];
  bit            lane_v [4][64];

  always #5 clk = ~clk;

  systolic_drain #(.OUT_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .of_data   (of_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (count),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus. A launch schedules column j for cycle cyc+j;
  // expected rows enter the scoreboard at launch time.
  task automatic tick(input bit v, input bit l, input bit exp, input logic [31:0] base);
    psum_row_t r;
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    in_valid = v;
    in_last  = l;
    if (v) begin
      for (int j = 0; j < 4; j++) begin
        lane_d[j][(cyc + j) % 64] = base + 32'(j);
        lane_v[j][(cyc + j) % 64] = 1'b1;
        r[j] = base + 32'(j);
      end
      if (exp) sb.push_back({l, r});
    end
    idx = cyc % 64;
    for (int j = 0; j < 4; j++) begin
      of_data[j] = lane_v[j][idx] ? lane_d[j][idx] : 32'hDEADBEEF;
      lane_v[j][idx] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_row: got %h expected none", {out_last, out_data});
      end else begin
        logic [128:0] e;
        e = sb.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL row_data: got %h expected %h", {out_last, out_data}, e);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) of_data[j] = 32'hDEADBEEF;

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count",     32'(count),     0);
    chk("rst_overflow",  32'(overflow),  0);

    // 1: single row, visible exactly at cycle 4
    for (int c = 0; c <= 6; c++) begin
      tick(c == 0, 0, 1, 100);
      if (c >= 1) chk("t1_out_valid", 32'(out_valid), 32'(c == 4));
      if (c == 5) chk("t1_count", 32'(count), 0);
    end
    chk("t1_sb_empty", sb.size(), 0);

    // 2: eight back-to-back rows, one per cycle out
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      tick(c < 8, 0, 1, 32'(16 * c));
      if (c >= 1) begin
        chk("t2_out_valid", 32'(out_valid), 32'(c >= 4 && c <= 11));
        chk("t2_count_le1", 32'(count <= 4'd1), 1);
        chk("t2_overflow",  32'(overflow), 0);
      end
    end
    chk("t2_sb_empty", sb.size(), 0);

    // 3: backpressure, ninth row dropped
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c <= 13; c++) tick(c < 9, 0, c < 8, 32'(1000 + 16 * c));
    chk("t3_count_full", 32'(count),    8);
    chk("t3_overflow",   32'(overflow), 1);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick(0, 0, 0, 0);
    chk("t3_count_drained", 32'(count),    0);
    chk("t3_overflow_kept", 32'(overflow), 1);
    chk("t3_sb_empty",      sb.size(),     0);

    // 4: full FIFO with a pop in the cycle the ninth row aligns
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c <= 11; c++) tick(c < 9, 0, 1, 32'(2000 + 16 * c));
    chk("t4_count_before", 32'(count), 8);
    out_ready = 1'b1;
    tick(0, 0, 0, 0);
    out_ready = 1'b0;
    chk("t4_count_after", 32'(count),    8);
    chk("t4_overflow",    32'(overflow), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick(0, 0, 0, 0);
    chk("t4_count_drained", 32'(count), 0);
    chk("t4_sb_empty",      sb.size(),  0);

    // 5: reset mid-flight, plus a launch while reset is held
    do_reset();
    tick(1, 0, 0, 3000);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 3100);
    rst = 1'b1;
    tick(0, 0, 0, 0);
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick(0, 0, 0, 0);
      chk("t5_out_valid", 32'(out_valid), 0);
      chk("t5_count",     32'(count),     0);
      chk("t5_overflow",  32'(overflow),  0);
    end

    // 6: last tag only on the third row
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      tick(c < 3, c == 2, 1, 32'(4000 + 16 * c));
      if (out_valid) chk("t6_out_last", 32'(out_last), 32'(c == 6));
    end
    chk("t6_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
